screen: RTL and testbench
=========================

SCREEN -- requirements
Module: screen

Interface
REQ-001 Parameter H_RES, 640, active pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_RES, 480, active lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, 0, asserted sync level (0 = active-low, VGA 640x480 default).
REQ-010 clk_in  input  1  pixel clock; single clock domain; all state updates on its rising edge.
REQ-011 rst_in  input  1  reset, synchronous, active-high.
REQ-012 sx_out  output  10  horizontal position, 0..H_TOTAL-1.
REQ-013 sy_out  output  10  vertical position, 0..V_TOTAL-1.
REQ-014 hsync_out  output  1  horizontal sync, level per SYNC_POL.
REQ-015 vsync_out  output  1  vertical sync, level per SYNC_POL.
REQ-016 de_out  output  1  data enable; high only in the active area.

Function
REQ-017 H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (default 525).
REQ-018 sx_out increments by 1 every clock; at H_TOTAL-1 it wraps to 0 on the next clock.
REQ-019 sy_out increments by 1 only on the clock where sx_out wraps; at V_TOTAL-1 with sx_out = H_TOTAL-1 both wrap to 0 together.
REQ-020 hsync_out asserted iff H_RES+H_FP <= sx_out < H_RES+H_FP+H_SYNC (default 656..751).
REQ-021 vsync_out asserted iff V_RES+V_FP <= sy_out < V_RES+V_FP+V_SYNC (default 490..491), independent of sx_out.
REQ-022 de_out high iff sx_out < H_RES and sy_out < V_RES.
REQ-023 All outputs registered; hsync_out, vsync_out and de_out always describe the same cycle as the concurrently presented sx_out/sy_out (zero relative skew); compute them from next-state counter values.
REQ-024 No output glitches; every output changes only on clk_in rising edges.
REQ-025 Counter values outside 0..TOTAL-1 never presented; the counters never skip a value.
REQ-026 Consumers detect frame start of vertical blanking as sy_out == V_RES && sx_out == 0, which occurs exactly once per frame for one cycle.
REQ-027 Frame period exactly H_TOTAL*V_TOTAL clocks (default 420000).

Reset
REQ-028 While rst_in is high at a rising edge: sx_out = 0, sy_out = 0, de_out = 1, hsync_out and vsync_out deasserted (1 for SYNC_POL = 0).
REQ-029 Reset asserted mid-line or mid-frame takes effect on the next edge regardless of position; counting resumes at (1,0) on the first edge after rst_in falls.

Structure
REQ-030 Shared package holds the default 640x480 timing constants and derived H_TOTAL/V_TOTAL; the module parameters default to them.
REQ-031 Single flat module; no sub-module required; counters sized to 10 bits, with an elaboration-time check that H_TOTAL and V_TOTAL fit in 10 bits.

Verification
REQ-032 Apply reset 3 cycles, release -> sx/sy = (0,0), de = 1, hsync = vsync = 1; next cycle sx = 1.
REQ-033 Run one line -> sx = 639 de = 1, sx = 640 de = 0; hsync = 0 exactly for sx 656..751 (96 cycles); sx 799 -> 0 with sy incrementing.
REQ-034 Run full frame -> vsync = 0 exactly on sy 490 and 491 (1600 clocks); sy 524 at sx 799 wraps to (0,0); period 420000 clocks.
REQ-035 Count de-high cycles per frame -> 307200; condition sy = 480 && sx = 0 seen exactly once per frame.
REQ-036 Assert rst_in at (300,200) for 1 cycle -> outputs at (0,0) reset values next edge, then normal counting.
REQ-037 Override parameters (e.g. H_RES 8, H_FP 2, H_SYNC 2, H_BP 2, V_RES 4, V_FP 1, V_SYNC 1, V_BP 1) -> H_TOTAL 14, V_TOTAL 7, sync/de windows per REQ-020..022.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared timing constants for the screen raster generator.
// Defaults describe standard VGA 640x480 at a 25.175 MHz pixel clock.
package screen_pkg;

    // Width of the position counters and the one-bit-wider compare domain.
    localparam int CNT_W   = 10;
    localparam int CNT_W1  = CNT_W + 1;
    localparam int CNT_MAX = 1 << CNT_W;

    // Horizontal timing in pixels.
    localparam int DEF_H_RES  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;

    // Vertical timing in lines.
    localparam int DEF_V_RES  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    // VGA 640x480 uses active-low syncs.
    localparam bit DEF_SYNC_POL = 1'b0;

    // Derived totals: 800 clocks per line, 525 lines per frame.
    localparam int DEF_H_TOTAL = DEF_H_RES + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_RES + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // True when pos lies in the half-open window [lo, hi).
    function automatic logic in_window(input logic [CNT_W1-1:0] pos,
                                       input logic [CNT_W1-1:0] lo,
                                       input logic [CNT_W1-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

    // Converts a logical "sync asserted" flag into the pin level for a polarity.
    function automatic logic sync_level(input logic asserted, input logic pol);
        return pol ? asserted : ~asserted;
    endfunction

endpackage

// File: rtl/screen.sv
// Raster timing generator: free-running pixel/line counters with
// registered sync and data-enable outputs aligned to the presented position.
module screen
    import screen_pkg::*;
#(
    parameter int H_RES    = DEF_H_RES,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_RES    = DEF_V_RES,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk_in,
    input  logic             rst_in,
    output logic [CNT_W-1:0] sx_out,
    output logic [CNT_W-1:0] sy_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             de_out
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    // Last legal counter values, where each counter wraps back to zero.
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    // Window bounds are one bit wider so an end bound equal to 1024 still compares correctly.
    localparam logic [CNT_W1-1:0] H_ACT_END = CNT_W1'(H_RES);
    localparam logic [CNT_W1-1:0] V_ACT_END = CNT_W1'(V_RES);
    localparam logic [CNT_W1-1:0] HS_LO     = CNT_W1'(H_RES + H_FP);
    localparam logic [CNT_W1-1:0] HS_HI     = CNT_W1'(H_RES + H_FP + H_SYNC);
    localparam logic [CNT_W1-1:0] VS_LO     = CNT_W1'(V_RES + V_FP);
    localparam logic [CNT_W1-1:0] VS_HI     = CNT_W1'(V_RES + V_FP + V_SYNC);

    // Output levels for the origin, used when reset forces the position to (0,0).
    localparam logic RST_HSYNC = sync_level(in_window('0, HS_LO, HS_HI), SYNC_POL);
    localparam logic RST_VSYNC = sync_level(in_window('0, VS_LO, VS_HI), SYNC_POL);
    localparam logic RST_DE    = (H_RES > 0) && (V_RES > 0);

    // Reject timings whose totals cannot be represented by the 10-bit counters.
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_size_check
        $error("screen: H_TOTAL (%0d) or V_TOTAL (%0d) exceeds %0d", H_TOTAL, V_TOTAL, CNT_MAX);
    end

    // Reject degenerate timings that would leave a counter with nothing to count.
    if (H_TOTAL < 1 || V_TOTAL < 1) begin : g_nonzero_check
        $error("screen: timing totals must be at least one");
    end

    logic [CNT_W-1:0]  sx_next;
    logic [CNT_W-1:0]  sy_next;
    logic [CNT_W1-1:0] sx_next_w;
    logic [CNT_W1-1:0] sy_next_w;
    logic              hsync_next;
    logic              vsync_next;
    logic              de_next;

    // Free-running next position: x advances every clock, y advances on the x wrap.
    always_comb begin
        sx_next = sx_out + 1'b1;
        sy_next = sy_out;
        if (sx_out == H_LAST) begin
            sx_next = '0;
            if (sy_out == V_LAST) begin
                sy_next = '0;
            end else begin
                sy_next = sy_out + 1'b1;
            end
        end
    end

    // Decode sync and data-enable from the next position so they land with it.
    always_comb begin
        sx_next_w  = {1'b0, sx_next};
        sy_next_w  = {1'b0, sy_next};
        hsync_next = sync_level(in_window(sx_next_w, HS_LO, HS_HI), SYNC_POL);
        vsync_next = sync_level(in_window(sy_next_w, VS_LO, VS_HI), SYNC_POL);
        de_next    = (sx_next_w < H_ACT_END) && (sy_next_w < V_ACT_END);
    end

    // Register position and decoded signals together; reset parks the raster at the origin.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sx_out    <= '0;
            sy_out    <= '0;
            hsync_out <= RST_HSYNC;
            vsync_out <= RST_VSYNC;
            de_out    <= RST_DE;
        end else begin
            sx_out    <= sx_next;
            sy_out    <= sy_next;
            hsync_out <= hsync_next;
            vsync_out <= vsync_next;
            de_out    <= de_next;
        end
    end

endmodule

// File: tb/tb_screen.sv
// Testbench for screen: a default VGA instance and a tiny override instance,
// both checked against a time-based model of the raster.
module tb_screen;

    localparam int D_HRES = 640, D_HFP = 16, D_HSYNC = 96, D_HBP = 48;
    localparam int D_VRES = 480, D_VFP = 10, D_VSYNC = 2,  D_VBP = 33;
    localparam int D_HT   = D_HRES + D_HFP + D_HSYNC + D_HBP;
    localparam int D_VT   = D_VRES + D_VFP + D_VSYNC + D_VBP;

    localparam int S_HRES = 8, S_HFP = 2, S_HSYNC = 2, S_HBP = 2;
    localparam int S_VRES = 4, S_VFP = 1, S_VSYNC = 1, S_VBP = 1;
    localparam int S_HT   = S_HRES + S_HFP + S_HSYNC + S_HBP;
    localparam int S_VT   = S_VRES + S_VFP + S_VSYNC + S_VBP;
    localparam int S_PER  = S_HT * S_VT;

    logic       clk = 1'b0;
    logic       rst_d = 1'b1;
    logic       rst_s = 1'b1;
    logic [9:0] sx_d, sy_d, sx_s, sy_s;
    logic       hs_d, vs_d, de_d, hs_s, vs_s, de_s;
    logic [22:0] obs_d, obs_s;

    int td = 0;
    int ts = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    screen dut_d (
        .clk_in(clk), .rst_in(rst_d),
        .sx_out(sx_d), .sy_out(sy_d),
        .hsync_out(hs_d), .vsync_out(vs_d), .de_out(de_d)
    );

    screen #(
        .H_RES(S_HRES), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
        .V_RES(S_VRES), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
        .SYNC_POL(1'b1)
    ) dut_s (
        .clk_in(clk), .rst_in(rst_s),
        .sx_out(sx_s), .sy_out(sy_s),
        .hsync_out(hs_s), .vsync_out(vs_s), .de_out(de_s)
    );

    assign obs_d = {sx_d, sy_d, hs_d, vs_d, de_d};
    assign obs_s = {sx_s, sy_s, hs_s, vs_s, de_s};

    // Clocks elapsed since each instance last saw reset at a rising edge.
    always @(posedge clk) begin
        td <= rst_d ? 0 : td + 1;
        ts <= rst_s ? 0 : ts + 1;
    end

    // Raster position and levels as a function of elapsed clocks.
    function automatic logic [22:0] model(int t, int hres, int hfp, int hsync, int hbp,
                                          int vres, int vfp, int vsync, int vbp, bit pol);
        int ht = hres + hfp + hsync + hbp;
        int vt = vres + vfp + vsync + vbp;
        int x  = t % ht;
        int y  = (t / ht) % vt;
        bit ha = (x >= hres + hfp) && (x < hres + hfp + hsync);
        bit va = (y >= vres + vfp) && (y < vres + vfp + vsync);
        bit de = (x < hres) && (y < vres);
        return {10'(x), 10'(y), pol ? ha : !ha, pol ? va : !va, de};
    endfunction

    function automatic logic [22:0] exp_d(int t);
        return model(t, D_HRES, D_HFP, D_HSYNC, D_HBP, D_VRES, D_VFP, D_VSYNC, D_VBP, 1'b0);
    endfunction

    function automatic logic [22:0] exp_s(int t);
        return model(t, S_HRES, S_HFP, S_HSYNC, S_HBP, S_VRES, S_VFP, S_VSYNC, S_VBP, 1'b1);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_d = 1'b1;
        rst_s = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_default got %h want %h", obs_d, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
        end
        checks++;
        if (obs_s !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_small got %h want %h", obs_s, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1});
        end
        rst_d = 1'b0;
        rst_s = 1'b0;
        tick();
        checks++;
        if (sx_d !== 10'd1 || sy_d !== 10'd0) begin
            errors++;
            $display("[TB] FAIL release_default got (%0d,%0d) want (1,0)", sx_d, sy_d);
        end
        checks++;
        if (sx_s !== 10'd1 || sy_s !== 10'd0) begin
            errors++;
            $display("[TB] FAIL release_small got (%0d,%0d) want (1,0)", sx_s, sy_s);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        rst_d = 1'b1;
        tick();
        rst_d = 1'b0;
        for (int i = 0; i < 2 * D_HT + 5; i++) begin
            tick();
            checks++;
            if (obs_d !== exp_d(td)) begin
                errors++;
                $display("[TB] FAIL line_model t=%0d got %h want %h", td, obs_d, exp_d(td));
            end
            if (td < D_HT && hs_d === 1'b0) hs_low++;
            if (td % D_HT == D_HRES - 1) begin
                checks++;
                if (de_d !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL de_last_active t=%0d got %b want 1", td, de_d);
                end
            end
            if (td % D_HT == D_HRES) begin
                checks++;
                if (de_d !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL de_first_blank t=%0d got %b want 0", td, de_d);
                end
            end
            if (td % D_HT == 0) begin
                checks++;
                if (sx_d !== 10'd0 || sy_d !== 10'(td / D_HT)) begin
                    errors++;
                    $display("[TB] FAIL line_wrap t=%0d got (%0d,%0d) want (0,%0d)", td, sx_d, sy_d, td / D_HT);
                end
            end
        end
        checks++;
        if (hs_low !== D_HSYNC) begin
            errors++;
            $display("[TB] FAIL hsync_width got %0d want %0d", hs_low, D_HSYNC);
        end
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 4; n++) begin
            int run_d = $urandom_range(20, 1800);
            int run_s = $urandom_range(3, 3 * S_PER);
            int longest = (run_d > run_s) ? run_d : run_s;
            for (int i = 0; i < longest; i++) begin
                tick();
                checks++;
                if (obs_d !== exp_d(td)) begin
                    errors++;
                    $display("[TB] FAIL mid_run_default t=%0d got %h want %h", td, obs_d, exp_d(td));
                end
                checks++;
                if (obs_s !== exp_s(ts)) begin
                    errors++;
                    $display("[TB] FAIL mid_run_small t=%0d got %h want %h", ts, obs_s, exp_s(ts));
                end
            end
            rst_d = 1'b1;
            rst_s = 1'b1;
            tick();
            rst_d = 1'b0;
            rst_s = 1'b0;
            checks++;
            if (obs_d !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
                errors++;
                $display("[TB] FAIL mid_reset_default got %h want %h", obs_d, {10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
            end
            checks++;
            if (obs_s !== {10'd0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL mid_reset_small got %h want %h", obs_s, {10'd0, 10'd0, 1'b0, 1'b0, 1'b1});
            end
            tick();
            checks++;
            if (sx_d !== 10'd1 || sy_d !== 10'd0 || sx_s !== 10'd1 || sy_s !== 10'd0) begin
                errors++;
                $display("[TB] FAIL mid_resume got (%0d,%0d)/(%0d,%0d) want (1,0)/(1,0)", sx_d, sy_d, sx_s, sy_s);
            end
        end
    endtask

    task automatic test_small_frame();
        int de_cnt[2]  = '{0, 0};
        int vs_cnt[2]  = '{0, 0};
        int blank[2]   = '{0, 0};
        int wraps[$];
        logic [9:0] px = '0, py = '0;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        for (int i = 0; i < 3 * S_PER; i++) begin
            px = sx_s;
            py = sy_s;
            tick();
            checks++;
            if (obs_s !== exp_s(ts)) begin
                errors++;
                $display("[TB] FAIL frame_model t=%0d got %h want %h", ts, obs_s, exp_s(ts));
            end
            if (px == 10'(S_HT - 1) && py == 10'(S_VT - 1) && sx_s == 10'd0 && sy_s == 10'd0)
                wraps.push_back(ts);
            if (ts >= S_PER && ts < 3 * S_PER) begin
                int f = ts / S_PER - 1;
                if (de_s === 1'b1) de_cnt[f]++;
                if (vs_s === 1'b1) vs_cnt[f]++;
                if (sy_s == 10'(S_VRES) && sx_s == 10'd0) blank[f]++;
            end
        end
        for (int f = 0; f < 2; f++) begin
            checks++;
            if (de_cnt[f] !== S_HRES * S_VRES) begin
                errors++;
                $display("[TB] FAIL frame_de_count f=%0d got %0d want %0d", f, de_cnt[f], S_HRES * S_VRES);
            end
            checks++;
            if (vs_cnt[f] !== S_VSYNC * S_HT) begin
                errors++;
                $display("[TB] FAIL frame_vsync_count f=%0d got %0d want %0d", f, vs_cnt[f], S_VSYNC * S_HT);
            end
            checks++;
            if (blank[f] !== 1) begin
                errors++;
                $display("[TB] FAIL frame_blank_start f=%0d got %0d want 1", f, blank[f]);
            end
        end
        checks++;
        if (wraps.size() !== 3) begin
            errors++;
            $display("[TB] FAIL frame_wrap_count got %0d want 3", wraps.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (wraps[k] - wraps[k-1] !== S_PER) begin
                    errors++;
                    $display("[TB] FAIL frame_period got %0d want %0d", wraps[k] - wraps[k-1], S_PER);
                end
            end
        end
    endtask

    task automatic test_random_reset();
        for (int i = 0; i < 2500; i++) begin
            rst_d = ($urandom_range(0, 299) == 0);
            rst_s = ($urandom_range(0, 49) == 0);
            tick();
            checks++;
            if (obs_d !== exp_d(td)) begin
                errors++;
                $display("[TB] FAIL random_default t=%0d got %h want %h", td, obs_d, exp_d(td));
            end
            checks++;
            if (obs_s !== exp_s(ts)) begin
                errors++;
                $display("[TB] FAIL random_small t=%0d got %h want %h", ts, obs_s, exp_s(ts));
            end
        end
        rst_d = 1'b0;
        rst_s = 1'b0;
    endtask

    initial begin
        $display("[TB] screen testbench start");
        test_reset();
        test_line();
        test_mid_reset();
        test_small_frame();
        test_random_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against the run never reaching its summary.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
